// File: rtl/ir_fetch_ctrl_if.sv
// rtl/ir_fetch_ctrl_if.sv - control, memory-read and IR-load signals of the fetch sequencer
interface ir_fetch_ctrl_if;
    logic        run;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        ir_ld;
    logic [31:0] ir_data;
    logic [31:0] pc;
    logic        busy;
    logic        err;

    modport master (
        input  run, stall, redirect, redirect_pc, mem_ready, mem_rdata,
        output mem_rd, mem_addr, ir_ld, ir_data, pc, busy, err
    );

    modport slave (
        output run, stall, redirect, redirect_pc, mem_ready, mem_rdata,
        input  mem_rd, mem_addr, ir_ld, ir_data, pc, busy, err
    );
endinterface

// File: rtl/ir_fetch_ctrl.sv
// rtl/ir_fetch_ctrl.sv - instruction fetch sequencer driving the IR load strobe
module ir_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             reset,
    ir_fetch_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, HOLD} state_t;

    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir_data;
    logic [31:0] pend_pc;
    logic        ir_ld;
    logic        err;
    logic        pend;
    logic        discard;
    logic [7:0]  tcnt;
    logic [31:0] rpc;

    assign rpc = bus.redirect_pc & ~32'h3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            ir_data <= 32'h0;
            pend_pc <= 32'h0;
            ir_ld   <= 1'b0;
            err     <= 1'b0;
            pend    <= 1'b0;
            discard <= 1'b0;
            tcnt    <= 8'h0;
        end else begin
            ir_ld <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.redirect) pc <= rpc;
                    if (bus.run) begin
                        state <= FETCH;
                        tcnt  <= 8'h0;
                    end
                end
                FETCH: begin
                    if (bus.mem_ready) begin
                        // A redirect seen at any point of this fetch turns the
                        // returned word into a discard and a forced refetch.
                        state   <= LOAD;
                        tcnt    <= 8'h0;
                        pend    <= 1'b0;
                        discard <= pend | bus.redirect;
                        if (bus.redirect) pend_pc <= rpc;
                        if (!(pend | bus.redirect)) begin
                            ir_data <= bus.mem_rdata;
                            ir_ld   <= 1'b1;
                        end
                    end else if (tcnt == TLAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        tcnt  <= 8'h0;
                        pend  <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 8'h1;
                        if (bus.redirect) begin
                            pend    <= 1'b1;
                            pend_pc <= rpc;
                        end
                    end
                end
                LOAD: begin
                    tcnt <= 8'h0;
                    if (discard) begin
                        pc      <= bus.redirect ? rpc : pend_pc;
                        discard <= 1'b0;
                        state   <= FETCH;
                    end else begin
                        pc <= bus.redirect ? rpc : pc + 32'd4;
                        if (bus.stall)    state <= HOLD;
                        else if (bus.run) state <= FETCH;
                        else              state <= IDLE;
                    end
                end
                HOLD: begin
                    tcnt <= 8'h0;
                    if (bus.redirect) pc <= rpc;
                    if (!bus.stall) state <= bus.run ? FETCH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd   = (state == FETCH);
    assign bus.mem_addr = pc;
    assign bus.pc       = pc;
    assign bus.ir_ld    = ir_ld;
    assign bus.ir_data  = ir_data;
    assign bus.busy     = (state != IDLE);
    assign bus.err      = err;
endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// tb/tb_ir_fetch_ctrl.sv - self-checking bench for ir_fetch_ctrl
module tb_ir_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ir_fetch_ctrl_if bus ();

    ir_fetch_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ctl = {run, stall, redirect, mem_ready}; ex = {mem_rd, ir_ld, busy, err}
    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] rpc;
        logic [31:0] rdata;
        logic [3:0]  ex;
        logic [31:0] e_data;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic [3:0] ctl, logic [31:0] rpc, logic [31:0] rdata,
                                logic [3:0] ex, logic [31:0] e_data, logic [31:0] e_pc);
        vec_t v;
        v.ctl = ctl; v.rpc = rpc; v.rdata = rdata;
        v.ex = ex; v.e_data = e_data; v.e_pc = e_pc;
        return v;
    endfunction

    function automatic logic [31:0] memf(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(logic run, logic stall, logic redir, logic [31:0] rpc,
                         logic rdy, logic [31:0] rdata);
        bus.run = run; bus.stall = stall; bus.redirect = redir;
        bus.redirect_pc = rpc; bus.mem_ready = rdy; bus.mem_rdata = rdata;
    endtask

    task automatic tick(logic run, logic stall, logic redir, logic [31:0] rpc,
                        logic rdy, logic [31:0] rdata);
        drive(run, stall, redir, rpc, rdy, rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [31:0] last, rt, exp_a;
        logic rv, first;
        int lat, wcnt, nld;

        tbl[0]  = mk(4'b1000, 32'h0,   32'h0,         4'b1010, 32'h0,         32'h0);
        tbl[1]  = mk(4'b1001, 32'h0,   32'h2008_0005, 4'b0110, 32'h2008_0005, 32'h0);
        tbl[2]  = mk(4'b1000, 32'h0,   32'h0,         4'b1010, 32'h2008_0005, 32'h4);
        tbl[3]  = mk(4'b1001, 32'h0,   32'h2009_0003, 4'b0110, 32'h2009_0003, 32'h4);
        tbl[4]  = mk(4'b0000, 32'h0,   32'h0,         4'b0000, 32'h2009_0003, 32'h8);
        tbl[5]  = mk(4'b0010, 32'h43,  32'h0,         4'b0000, 32'h2009_0003, 32'h40);
        tbl[6]  = mk(4'b1000, 32'h0,   32'h0,         4'b1010, 32'h2009_0003, 32'h40);
        tbl[7]  = mk(4'b0000, 32'h0,   32'h0,         4'b1010, 32'h2009_0003, 32'h40);
        tbl[8]  = mk(4'b1000, 32'h0,   32'h0,         4'b1010, 32'h2009_0003, 32'h40);
        tbl[9]  = mk(4'b1000, 32'h0,   32'h0,         4'b1010, 32'h2009_0003, 32'h40);
        tbl[10] = mk(4'b1001, 32'h0,   32'h1111_2222, 4'b0110, 32'h1111_2222, 32'h40);
        tbl[11] = mk(4'b1100, 32'h0,   32'h0,         4'b0010, 32'h1111_2222, 32'h44);
        tbl[12] = mk(4'b1100, 32'h0,   32'h0,         4'b0010, 32'h1111_2222, 32'h44);
        tbl[13] = mk(4'b1100, 32'h0,   32'h0,         4'b0010, 32'h1111_2222, 32'h44);
        tbl[14] = mk(4'b1100, 32'h0,   32'h0,         4'b0010, 32'h1111_2222, 32'h44);
        tbl[15] = mk(4'b1100, 32'h0,   32'h0,         4'b0010, 32'h1111_2222, 32'h44);
        tbl[16] = mk(4'b1000, 32'h0,   32'h0,         4'b1010, 32'h1111_2222, 32'h44);
        tbl[17] = mk(4'b1001, 32'h0,   32'h3333_4444, 4'b0110, 32'h3333_4444, 32'h44);
        tbl[18] = mk(4'b1100, 32'h0,   32'h0,         4'b0010, 32'h3333_4444, 32'h48);
        tbl[19] = mk(4'b1110, 32'h103, 32'h0,         4'b0010, 32'h3333_4444, 32'h100);
        tbl[20] = mk(4'b1000, 32'h0,   32'h0,         4'b1010, 32'h3333_4444, 32'h100);
        tbl[21] = mk(4'b1011, 32'h200, 32'hABCD_0001, 4'b0010, 32'h3333_4444, 32'h100);
        tbl[22] = mk(4'b1000, 32'h0,   32'h0,         4'b1010, 32'h3333_4444, 32'h200);
        tbl[23] = mk(4'b1001, 32'h0,   32'h0000_0055, 4'b0110, 32'h0000_0055, 32'h200);
        tbl[24] = mk(4'b0000, 32'h0,   32'h0,         4'b0000, 32'h0000_0055, 32'h204);

        do_reset();
        chk("reset.mem_rd",  {31'h0, bus.mem_rd}, 32'h0);
        chk("reset.ir_ld",   {31'h0, bus.ir_ld},  32'h0);
        chk("reset.ir_data", bus.ir_data,         32'h0);
        chk("reset.pc",      bus.pc,              RESET_PC);
        chk("reset.addr",    bus.mem_addr,        RESET_PC);
        chk("reset.busy",    {31'h0, bus.busy},   32'h0);
        chk("reset.err",     {31'h0, bus.err},    32'h0);

        for (int i = 0; i < 25; i++) begin
            tick(tbl[i].ctl[3], tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].rpc,
                 tbl[i].ctl[0], tbl[i].rdata);
            chk($sformatf("v%0d.mem_rd", i), {31'h0, bus.mem_rd}, {31'h0, tbl[i].ex[3]});
            chk($sformatf("v%0d.ir_ld", i),  {31'h0, bus.ir_ld},  {31'h0, tbl[i].ex[2]});
            chk($sformatf("v%0d.busy", i),   {31'h0, bus.busy},   {31'h0, tbl[i].ex[1]});
            chk($sformatf("v%0d.err", i),    {31'h0, bus.err},    {31'h0, tbl[i].ex[0]});
            chk($sformatf("v%0d.ir_data", i), bus.ir_data, tbl[i].e_data);
            chk($sformatf("v%0d.pc", i),      bus.pc,      tbl[i].e_pc);
            chk($sformatf("v%0d.addr", i),    bus.mem_addr, tbl[i].e_pc);
        end

        // redirect while FETCH waits; second redirect overwrites the first
        tick(1'b1, 1'b0, 1'b1, 32'h8,    1'b0, 32'h0);
        chk("pend.fetch_pc", bus.mem_addr, 32'h8);
        tick(1'b1, 1'b0, 1'b1, 32'h3000, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b1, 32'h1003, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0);
        chk("pend.hold_addr", bus.mem_addr, 32'h8);
        chk("pend.ir_ld0", {31'h0, bus.ir_ld}, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'hDEAD_DEAD);
        chk("pend.no_ld",  {31'h0, bus.ir_ld},  32'h0);
        chk("pend.exit_rd", {31'h0, bus.mem_rd}, 32'h0);
        chk("pend.ir_kept", bus.ir_data, 32'h55);
        tick(1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0);
        chk("pend.new_rd",   {31'h0, bus.mem_rd}, 32'h1);
        chk("pend.new_addr", bus.mem_addr, 32'h1000);
        tick(1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'hBEEF_0001);
        chk("pend.ld",      {31'h0, bus.ir_ld}, 32'h1);
        chk("pend.ld_data", bus.ir_data, 32'hBEEF_0001);
        tick(1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0);
        chk("pend.next_pc", bus.pc, 32'h1004);

        // timeout with mem_ready held low
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cnt = bus.mem_rd ? 1 : 0;
        for (int k = 0; k < 40 && !bus.err; k++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            if (bus.mem_rd) cnt++;
        end
        chk("tmo.cycles", cnt, TIMEOUT);
        chk("tmo.err",    {31'h0, bus.err},    32'h1);
        chk("tmo.mem_rd", {31'h0, bus.mem_rd}, 32'h0);
        chk("tmo.busy",   {31'h0, bus.busy},   32'h0);
        chk("tmo.pc",     bus.pc, 32'h1004);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("tmo.restart_rd",   {31'h0, bus.mem_rd}, 32'h1);
        chk("tmo.restart_addr", bus.mem_addr, 32'h1004);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0077);
        chk("tmo.restart_ld", bus.ir_data, 32'h77);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("tmo.err_sticky", {31'h0, bus.err}, 32'h1);

        // PC wraps from the top of the address space
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        chk("wrap.addr", bus.mem_addr, 32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0099);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap.pc", bus.pc, 32'h0);

        // asynchronous reset in the middle of a FETCH
        tick(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        chk("rst.pre_addr", bus.mem_addr, 32'h80);
        #2 reset = 1'b1;
        #1;
        chk("rst.pc",      bus.pc, RESET_PC);
        chk("rst.mem_rd",  {31'h0, bus.mem_rd}, 32'h0);
        chk("rst.err",     {31'h0, bus.err},    32'h0);
        chk("rst.busy",    {31'h0, bus.busy},   32'h0);
        chk("rst.ir_data", bus.ir_data, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst.no_ld", {31'h0, bus.ir_ld}, 32'h0);

        // randomized run against a transaction-level model: every load must
        // carry the word at the last redirect target, else previous address + 4
        do_reset();
        first = 1'b1; rv = 1'b0; last = RESET_PC; rt = 32'h0;
        lat = 0; wcnt = 0; nld = 0;
        for (int c = 0; c < 3000; c++) begin
            logic run, stall, redir, rdy;
            logic [31:0] rpc, rdata;
            if (bus.ir_ld) begin
                exp_a = rv ? rt : (first ? RESET_PC : last + 32'd4);
                chk($sformatf("rnd.ld%0d", nld), bus.ir_data, memf(exp_a));
                last = exp_a; first = 1'b0; rv = 1'b0; nld++;
            end
            rdy = 1'b0; rdata = 32'h0;
            if (bus.mem_rd) begin
                if (wcnt == lat) begin
                    rdy = 1'b1; rdata = memf(bus.mem_addr);
                    wcnt = 0; lat = int'($urandom_range(0, 5));
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            run   = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 4) == 0);
            redir = ($urandom_range(0, 19) == 0);
            rpc   = $urandom;
            if (redir) begin
                rv = 1'b1; rt = rpc & ~32'h3;
            end
            tick(run, stall, redir, rpc, rdy, rdata);
        end
        chk("rnd.err", {31'h0, bus.err}, 32'h0);
        chk("rnd.enough_loads", {31'h0, (nld > 150)}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ir_fetch_ctrl.md
# ir_fetch_ctrl

Instruction-fetch sequencer that drives the load side of the 32-bit IR register. It reads instruction words from memory over a ready/request handshake and pulses `ir_ld` with the fetched word. It owns the program counter and supports stall, redirect (branch/jump) and a memory timeout. It sits between instruction memory and the IR register in the multicycle MIPS datapath.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `TIMEOUT`, 16, maximum FETCH cycles without `mem_ready` before error (1..255).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `run`  in  1  level; 1 = fetch continuously, 0 = stop after current fetch.
- `stall`  in  1  level; hold before the next fetch.
- `redirect`  in  1  one-cycle pulse; replace PC with `redirect_pc`.
- `redirect_pc`  in  32  new PC; bits [1:0] forced to 0.
- `mem_rd`  out  1  memory read request.
- `mem_addr`  out  32  read address, always equal to `pc`.
- `mem_ready`  in  1  memory has `mem_rdata` valid this cycle.
- `mem_rdata`  in  32  instruction word.
- `ir_ld`  out  1  one-cycle load strobe to IR.
- `ir_data`  out  32  registered fetched word, valid while `ir_ld`=1 and held after.
- `pc`  out  32  current fetch address.
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky timeout flag, cleared only by reset.

## Operation
- States: IDLE, FETCH, LOAD, HOLD.
- IDLE: `mem_rd`=0. If `run`=1, go to FETCH.
- FETCH:
  - `mem_rd`=1, `mem_addr`=`pc`. The timeout counter is cleared on entry and increments on each cycle with `mem_ready`=0.
  - On `mem_ready`=1: capture `mem_rdata` into `ir_data` and go to LOAD.
  - When the counter reaches TIMEOUT: set `err`=1, drop `mem_rd`, go to IDLE.
- LOAD:
  - `ir_ld`=1 for exactly one cycle.
  - `pc` <= `pc`+4 (wraps mod 2^32), or `redirect_pc` if `redirect`=1 this cycle.
  - Next state: HOLD if `stall`=1, else FETCH if `run`=1, else IDLE.
- HOLD: `mem_rd`=0. When `stall`=0, go to FETCH if `run`=1, else IDLE.
- Redirect:
  - In IDLE or HOLD: `pc` <= `redirect_pc`; the state is otherwise unaffected.
  - In FETCH: set a pending flag and keep the request until `mem_ready`. The returned word is discarded (no `ir_ld`, `ir_data` unchanged). `pc` <= latched `redirect_pc`, then re-enter FETCH and clear the flag.
  - A later redirect while one is pending overwrites the latched target.
- `run`=0 never aborts an outstanding FETCH; only reset or the timeout does.
- `err`=1 does not block a later `run`-initiated fetch.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, `mem_addr`=RESET_PC, `mem_rd`=0, `ir_ld`=0, `ir_data`=0, `busy`=0, `err`=0, pending flag 0, timeout counter 0.
- Reset asserted mid-fetch forces the above values immediately; the memory transaction is abandoned.
- Cycle-level sequence:
  - `run` sampled 1 in IDLE at edge n: `mem_rd`=1 during cycle n+1.
  - `mem_ready` sampled at edge m: `ir_ld`=1 during cycle m+1, and the new `pc` is visible in cycle m+2.
  - Zero-wait memory with `run`=1 and no stall: one instruction every 2 cycles (FETCH, LOAD).
- `redirect` and `mem_ready` in the same FETCH cycle: the word is discarded and FETCH of `redirect_pc` starts 2 cycles later. There is one extra FETCH-exit cycle, during which `mem_rd`=0.
- `stall` and `redirect` in the same HOLD cycle: `pc` updates and the state stays HOLD.
- Timeout: with `mem_ready` held 0, `err` rises after exactly TIMEOUT FETCH cycles, and `mem_rd` falls in the same cycle.

## Test plan
- Reset, then `run`=1 with zero-wait memory returning 32'h2008_0005, 32'h2009_0003 → `ir_ld` pulses in cycles 3 and 5 with those words; `pc` = 0, 4, 8.
- Memory wait of 3 cycles at `pc`=32'h40 → `mem_rd` high for 4 cycles with `mem_addr`=32'h40; one `ir_ld`; `pc`=32'h44.
- `redirect`=1 with `redirect_pc`=32'h0000_1003 during a waiting FETCH at `pc`=8 → no `ir_ld` for the word at 8; next `mem_addr`=32'h1000; then `ir_ld` for the word at 32'h1000.
- `stall`=1 asserted during LOAD for 5 cycles → HOLD with `mem_rd`=0 for those cycles; FETCH resumes at `pc`+4 the cycle after `stall` drops.
- `mem_ready` held 0, TIMEOUT=16 → `err`=1 and `busy`=0 after 16 FETCH cycles; `pc` unchanged; a new `run` restarts the fetch at the same `pc`.
- Reset pulsed mid-FETCH with `pc`=32'h80 → `pc`=RESET_PC, `mem_rd`=0, `err`=0 immediately; no `ir_ld` pulse.
